controller_programmable_nch: RTL and testbench
==============================================

Name: controller_programmable_nch

Overview:
- Next-generation programmable near-subarray controller for a configurable number (NUM_CH) of row-streaming channels.
- Holds a loadable instruction buffer and sequences the ALU (opcode and sources) per instruction, with per-instruction repeat counts.
- Tracks per-channel column and row pointers and inserts row-activation waits whenever a channel's column pointer wraps.
- New in this generation: halt instruction, done/busy status, command gating by state, and prioritised servicing of simultaneous row wraps.

Parameters:
NUM_CH, 3, number of row-streaming channels
CH_IDX_W, 2, width of the channel select field
NUM_INSTR, 8, instruction buffer depth
PC_W, 3, program counter width (log2 NUM_INSTR)
OP_W, 1, ALU opcode width
SRC_W, 2, ALU source select width
COND_W, 3, shift condition code width
NUM_COLS, 64, columns per row
COL_W, 6, column and repeat counter width
ROW_W, 10, row address width
WAIT_CYCLES, 9, cycles per row activation
CMD_W, 4, command width
BUS_W, 32, command data width; INSTR_W = PC_W+1+OP_W+2*SRC_W+NUM_CH*(COND_W+1)+COL_W, must be <= BUS_W (27 at defaults)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  begin program at pc 0
cmd_valid  in  1  command strobe
cmd  in  CMD_W  0=SET_ROW_START, 1=SET_ROW_END, 2=LOAD_INSTR
cmd_chan  in  CH_IDX_W  channel for SET_ROW_*
cmd_row_addr  in  ROW_W  row address; low PC_W bits = slot for LOAD_INSTR
cmd_data  in  BUS_W  instruction word in [INSTR_W-1:0]
cmd_ready  out  1  high only in IDLE
adder_equal_flag  in  1  ALU equal flag
adder_less_flag  in  1  ALU less flag
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at program end
pc  out  PC_W  current pc
opcode  out  OP_W  current instruction opcode
src1, src2  out  SRC_W each  ALU source selects
shift  out  NUM_CH  per-channel column shift
shift_dir  out  NUM_CH  per-channel direction (1 = write)
row_active  out  NUM_CH  one-hot channel being activated
row_addr_out  out  ROW_W  row being activated
read_or_write  out  1  shift_dir of the active channel; 0 when none active

Behaviour:
- Clocking and reset: clk; reset asynchronous, active-high.
  - Reset sets IDLE, pc=0, repeat counter 0, all col/row counters and start/end registers 0, pending/finished masks 0, all outputs 0.
  - Instruction buffer is not reset.
  - Reset mid-operation aborts immediately; no done pulse.
- Instruction fields, LSB first: next_pc, halt, opcode, src1, src2, cond[c] (COND_W per channel, ch0 lowest), dir[c] (1 bit per channel), repeat (COL_W).
  - opcode, src1, src2, shift_dir and pc are driven combinationally from buf[pc] in every state.
- Commands:
  - Accepted only when cmd_valid and state==IDLE; ignored otherwise.
  - SET_ROW_* with cmd_chan >= NUM_CH is ignored.
  - LOAD_INSTR writes buf[cmd_row_addr[PC_W-1:0]] on the clock edge.
- States: IDLE, COMPUTE, ROW_WAIT, DONE.
  - IDLE, start=1: go to COMPUTE. pc=0, rep=0, col[c]=0, row[c]=row_start[c], pending=0, fin=0. start in any other state is ignored.
  - COMPUTE: shift[c] is decoded from cond[c]:
    - 0 never, 1 always, 2 eq, 3 !eq, 4 less, 5 !less & !eq; others 0.
    - shift[c] is forced 0 if fin[c] is set.
    - Outside COMPUTE, shift = 0.
  - COMPUTE, each cycle: col[c] += shift[c].
    - If shift[c] and col[c]==NUM_COLS-1: col[c] wraps to 0.
    - On that wrap, if row[c]!=row_end[c]: row[c]+1 mod 2^ROW_W and pending[c]=1. Otherwise fin[c]=1.
  - COMPUTE, repeat handling: rep increments each cycle. When rep==repeat: rep=0 and pc=next_pc; repeat=0 executes once.
  - COMPUTE, priority:
    - halt completes (rep==repeat with halt=1), or all fin set after the update: go to DONE, pending discarded.
    - else any pending: go to ROW_WAIT.
    - else stay in COMPUTE.
  - ROW_WAIT: services the lowest-index pending channel k for exactly WAIT_CYCLES cycles.
    - row_active=onehot(k), row_addr_out=row[k], read_or_write=dir[k].
    - pc, rep and col are frozen.
    - On the last cycle pending[k] is cleared; go to the next pending channel (wait restarts) or to COMPUTE.
  - DONE: done=1 for one cycle, then IDLE.

Test Plan:
- Load buf[0] (repeat=2, halt=1, cond all 1), row_start=row_end=0 for all channels, start -> 3 COMPUTE cycles, shift=3'b111 each cycle, done pulse on cycle 4, busy low on cycle 5.
- NUM_COLS=4, ch0 cond=1, row_start0=5, row_end0=7 -> after 4 shifts row_active=001 and row_addr_out=6 for exactly 9 cycles, then COMPUTE resumes with col0=0.
- ch0 and ch2 wrap in the same cycle -> ch0 waits 9 cycles, then ch2 waits 9 cycles (row_active=100), 18 stall cycles total, pc unchanged.
- cond=2 with adder_equal_flag toggling 1,0,1 -> shift0 = 1,0,1 and col0=2; cond=5 with less=0, eq=0 -> shift=1.
- LOAD_INSTR or start asserted while busy -> buffer contents and pc unchanged, cmd_ready=0.
- Assert reset during ROW_WAIT -> next cycle row_active=0, state IDLE, no done pulse; previously loaded program reruns correctly after start.

Source files
------------

// File: rtl/controller_programmable_nch_if.sv
// Command bus between a host and the programmable near-subarray controller.
// The host drives command fields; the controller reports readiness.
interface controller_programmable_nch_if #(
    parameter int CMD_W    = 4,
    parameter int CH_IDX_W = 2,
    parameter int ROW_W    = 10,
    parameter int BUS_W    = 32
);
    logic                cmd_valid;
    logic [CMD_W-1:0]    cmd;
    logic [CH_IDX_W-1:0] cmd_chan;
    logic [ROW_W-1:0]    cmd_row_addr;
    logic [BUS_W-1:0]    cmd_data;
    logic                cmd_ready;

    modport master (
        output cmd_valid, cmd, cmd_chan, cmd_row_addr, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd, cmd_chan, cmd_row_addr, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/controller_programmable_nch.sv
// Programmable multi-channel row-streaming controller: instruction buffer,
// per-channel column/row pointers and prioritised row-activation waits.
module controller_programmable_nch #(
    parameter int NUM_CH      = 3,
    parameter int CH_IDX_W    = 2,
    parameter int NUM_INSTR   = 8,
    parameter int PC_W        = 3,
    parameter int OP_W        = 1,
    parameter int SRC_W       = 2,
    parameter int COND_W      = 3,
    parameter int NUM_COLS    = 64,
    parameter int COL_W       = 6,
    parameter int ROW_W       = 10,
    parameter int WAIT_CYCLES = 9,
    parameter int CMD_W       = 4,
    parameter int BUS_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    controller_programmable_nch_if.slave bus,
    input  logic              adder_equal_flag,
    input  logic              adder_less_flag,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc,
    output logic [OP_W-1:0]   opcode,
    output logic [SRC_W-1:0]  src1,
    output logic [SRC_W-1:0]  src2,
    output logic [NUM_CH-1:0] shift,
    output logic [NUM_CH-1:0] shift_dir,
    output logic [NUM_CH-1:0] row_active,
    output logic [ROW_W-1:0]  row_addr_out,
    output logic              read_or_write
);
    localparam int OFF_HALT = PC_W;
    localparam int OFF_OP   = PC_W + 1;
    localparam int OFF_S1   = OFF_OP + OP_W;
    localparam int OFF_S2   = OFF_S1 + SRC_W;
    localparam int OFF_COND = OFF_S2 + SRC_W;
    localparam int OFF_DIR  = OFF_COND + NUM_CH * COND_W;
    localparam int OFF_REP  = OFF_DIR + NUM_CH;
    localparam int INSTR_W  = OFF_REP + COL_W;
    localparam int WAIT_W   = $clog2(WAIT_CYCLES);

    localparam logic [CMD_W-1:0] CMD_SET_START = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SET_END   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_LOAD      = CMD_W'(2);

    typedef enum logic [1:0] {
        IDLE, COMPUTE, ROW_WAIT, DONE
    } state_t;

    state_t state;

    logic [INSTR_W-1:0]  ibuf [NUM_INSTR];
    logic [INSTR_W-1:0]  cur;
    logic [COL_W-1:0]    rep;
    logic [WAIT_W-1:0]   wcnt;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   fin;
    logic [COL_W-1:0]    col       [NUM_CH];
    logic [ROW_W-1:0]    row       [NUM_CH];
    logic [ROW_W-1:0]    row_start [NUM_CH];
    logic [ROW_W-1:0]    row_end   [NUM_CH];

    logic [NUM_CH-1:0]   wrap;
    logic [NUM_CH-1:0]   pend_nx;
    logic [NUM_CH-1:0]   fin_nx;
    logic [NUM_CH-1:0]   k_hot;
    logic [NUM_CH-1:0]   pend_left;
    logic [CH_IDX_W-1:0] k;
    logic                rep_done;
    logic                go_done;
    logic                cmd_ok;
    logic                chan_ok;
    logic                unused_bits;

    assign cur       = ibuf[pc];
    assign opcode    = cur[OFF_OP +: OP_W];
    assign src1      = cur[OFF_S1 +: SRC_W];
    assign src2      = cur[OFF_S2 +: SRC_W];
    assign shift_dir = cur[OFF_DIR +: NUM_CH];
    assign rep_done  = (rep == cur[OFF_REP +: COL_W]);

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign bus.cmd_ready = (state == IDLE);

    assign cmd_ok  = bus.cmd_valid && (state == IDLE);
    assign chan_ok = (bus.cmd_chan < CH_IDX_W'(NUM_CH));

    assign unused_bits = ^{1'b0,
                           bus.cmd_row_addr[ROW_W-1:PC_W],
                           bus.cmd_data[BUS_W-1:INSTR_W]};

    always_comb begin
        shift   = '0;
        wrap    = '0;
        pend_nx = pending;
        fin_nx  = fin;
        for (int c = 0; c < NUM_CH; c++) begin
            case (cur[OFF_COND + c * COND_W +: COND_W])
                COND_W'(1): shift[c] = 1'b1;
                COND_W'(2): shift[c] = adder_equal_flag;
                COND_W'(3): shift[c] = !adder_equal_flag;
                COND_W'(4): shift[c] = adder_less_flag;
                COND_W'(5): shift[c] = !adder_less_flag && !adder_equal_flag;
                default:    shift[c] = 1'b0;
            endcase
            if (state != COMPUTE || fin[c])
                shift[c] = 1'b0;
            wrap[c] = shift[c] && (col[c] == COL_W'(NUM_COLS - 1));
            if (wrap[c]) begin
                if (row[c] != row_end[c])
                    pend_nx[c] = 1'b1;
                else
                    fin_nx[c] = 1'b1;
            end
        end
        go_done = (rep_done && cur[OFF_HALT]) || (&fin_nx);
    end

    // Lowest-index pending channel is serviced first.
    always_comb begin
        k = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (pending[c])
                k = CH_IDX_W'(c);
    end

    assign k_hot     = NUM_CH'(1) << k;
    assign pend_left = pending & ~k_hot;

    assign row_active    = (state == ROW_WAIT) ? k_hot : '0;
    assign row_addr_out  = (state == ROW_WAIT) ? row[k] : '0;
    assign read_or_write = (state == ROW_WAIT) && shift_dir[k];

    always_ff @(posedge clk) begin
        if (cmd_ok && bus.cmd == CMD_LOAD)
            ibuf[bus.cmd_row_addr[PC_W-1:0]] <= bus.cmd_data[INSTR_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            rep     <= '0;
            wcnt    <= '0;
            pending <= '0;
            fin     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                col[c]       <= '0;
                row[c]       <= '0;
                row_start[c] <= '0;
                row_end[c]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_ok && chan_ok) begin
                        if (bus.cmd == CMD_SET_START)
                            row_start[bus.cmd_chan] <= bus.cmd_row_addr;
                        if (bus.cmd == CMD_SET_END)
                            row_end[bus.cmd_chan] <= bus.cmd_row_addr;
                    end
                    if (start) begin
                        state   <= COMPUTE;
                        pc      <= '0;
                        rep     <= '0;
                        wcnt    <= '0;
                        pending <= '0;
                        fin     <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            col[c] <= '0;
                            row[c] <= row_start[c];
                        end
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (shift[c])
                            col[c] <= wrap[c] ? '0 : col[c] + COL_W'(1);
                        if (wrap[c] && row[c] != row_end[c])
                            row[c] <= row[c] + ROW_W'(1);
                    end
                    fin <= fin_nx;
                    if (rep_done) begin
                        rep <= '0;
                        pc  <= cur[PC_W-1:0];
                    end else begin
                        rep <= rep + COL_W'(1);
                    end
                    wcnt <= '0;
                    if (go_done) begin
                        state   <= DONE;
                        pending <= '0;
                    end else begin
                        pending <= pend_nx;
                        if (|pend_nx)
                            state <= ROW_WAIT;
                    end
                end
                ROW_WAIT: begin
                    if (wcnt == WAIT_W'(WAIT_CYCLES - 1)) begin
                        wcnt    <= '0;
                        pending <= pend_left;
                        if (pend_left == '0)
                            state <= COMPUTE;
                    end else begin
                        wcnt <= wcnt + WAIT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_programmable_nch.sv
// Directed self-checking bench for controller_programmable_nch
// (built with NUM_COLS=4 so row wraps happen quickly).
module tb_controller_programmable_nch;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        eq = 0;
    logic        less = 0;
    logic        busy, done, rw;
    logic [2:0]  pc;
    logic [0:0]  opcode;
    logic [1:0]  src1, src2;
    logic [2:0]  shift, shift_dir, row_active;
    logic [9:0]  row_addr;
    int          checks = 0;
    int          errors = 0;
    int          n;

    controller_programmable_nch_if cbus ();

    controller_programmable_nch #(.NUM_COLS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(cbus),
        .adder_equal_flag(eq), .adder_less_flag(less),
        .busy(busy), .done(done), .pc(pc), .opcode(opcode),
        .src1(src1), .src2(src2), .shift(shift),
        .shift_dir(shift_dir), .row_active(row_active),
        .row_addr_out(row_addr), .read_or_write(rw)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(
        input logic [2:0] npc, input logic halt, input logic op,
        input logic [1:0] s1, input logic [1:0] s2,
        input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
        input logic [2:0] dir, input logic [5:0] rep);
        mk = {5'b0, rep, dir, c2, c1, c0, s2, s1, op, halt, npc};
    endfunction

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [1:0] ch,
                        input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        cbus.cmd_valid = 1; cbus.cmd = c; cbus.cmd_chan = ch;
        cbus.cmd_row_addr = a; cbus.cmd_data = d;
        @(negedge clk);
        cbus.cmd_valid = 0;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; #1;
    endtask

    task automatic do_reset;
        @(negedge clk); reset = 1; start = 0; eq = 0; less = 0;
        @(negedge clk); reset = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, cbus.cmd_ready, pc, shift, row_active, row_addr, rw}
            !== {1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b %b %b %0d %b %b %0d %b",
                     busy, done, cbus.cmd_ready, pc, shift, row_active,
                     row_addr, rw);
        end
        reset = 0;
    endtask

    task automatic test_basic;
        send(2, 0, 0, mk(0, 1, 1, 2, 1, 1, 1, 1, 3'b101, 2));
        pulse_start;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({busy, done, cbus.cmd_ready, shift} !== {3'b100, 3'b111}) begin
                errors++;
                $display("FAIL basic_c%0d got b=%b d=%b r=%b s=%b want 1 0 0 111",
                         i, busy, done, cbus.cmd_ready, shift);
            end
            tick;
        end
        checks++;
        if ({opcode, src1, src2, shift_dir} !== {1'b1, 2'd2, 2'd1, 3'b101}) begin
            errors++;
            $display("FAIL basic_fields got %b %0d %0d %b", opcode, src1, src2,
                     shift_dir);
        end
        checks++;
        if ({busy, done, shift} !== {2'b11, 3'b000}) begin
            errors++;
            $display("FAIL basic_done got b=%b d=%b s=%b want 1 1 000",
                     busy, done, shift);
        end
        tick;
        checks++;
        if ({busy, done, cbus.cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL basic_idle got b=%b d=%b r=%b want 0 0 1",
                     busy, done, cbus.cmd_ready);
        end
    endtask

    task automatic test_row_wait;
        do_reset;
        send(0, 0, 5, 0);
        send(1, 0, 7, 0);
        send(2, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 0));
        pulse_start;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({shift, row_active} !== {3'b001, 3'b000}) begin
                    errors++;
                    $display("FAIL rw_shift p%0d i%0d got s=%b ra=%b want 001 000",
                             p, i, shift, row_active);
                end
                tick;
            end
            if (p < 2) begin
                for (int i = 0; i < 9; i++) begin
                    checks++;
                    if ({row_active, row_addr, rw, shift}
                        !== {3'b001, 10'(6 + p), 1'b1, 3'b000}) begin
                        errors++;
                        $display("FAIL rw_wait p%0d i%0d got ra=%b a=%0d w=%b s=%b want 001 %0d 1 000",
                                 p, i, row_active, row_addr, rw, shift, 6 + p);
                    end
                    tick;
                end
            end
        end
        checks++;
        if ({shift, row_active, busy} !== {3'b000, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL rw_finished got s=%b ra=%b b=%b want 000 000 1",
                     shift, row_active, busy);
        end
    endtask

    task automatic test_dual_wrap;
        do_reset;
        send(0, 0, 0, 0);
        send(1, 0, 1, 0);
        send(0, 2, 3, 0);
        send(1, 2, 4, 0);
        send(1, 3, 0, 0);
        send(2, 0, 0, mk(1, 0, 0, 0, 0, 1, 0, 1, 3'b100, 5));
        send(2, 0, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        pulse_start;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (shift !== 3'b101) begin
                errors++;
                $display("FAIL dual_shift i%0d got %b want 101", i, shift);
            end
            tick;
        end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if ({row_active, row_addr, rw, pc} !== ((i < 9) ?
                {3'b001, 10'd1, 1'b0, 3'd0} : {3'b100, 10'd4, 1'b1, 3'd0})) begin
                errors++;
                $display("FAIL dual_wait i%0d got ra=%b a=%0d w=%b pc=%0d",
                         i, row_active, row_addr, rw, pc);
            end
            tick;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({row_active, shift, pc} !== {3'b000, 3'b101, 3'd0}) begin
                errors++;
                $display("FAIL dual_resume i%0d got ra=%b s=%b pc=%0d want 000 101 0",
                         i, row_active, shift, pc);
            end
            tick;
        end
        checks++;
        if ({pc, shift, busy, done} !== {3'd1, 3'b000, 2'b10}) begin
            errors++;
            $display("FAIL dual_pc got pc=%0d s=%b b=%b d=%b want 1 000 1 0",
                     pc, shift, busy, done);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL dual_done got %b want 1", done);
        end
    endtask

    task automatic test_cond;
        do_reset;
        send(2, 0, 0, mk(1, 0, 0, 0, 0, 2, 0, 0, 3'b000, 2));
        send(2, 0, 1, mk(0, 1, 0, 0, 0, 5, 4, 3, 3'b000, 0));
        eq = 1;
        pulse_start;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick;
                eq = (i == 2);
                #1;
            end
            checks++;
            if (shift !== ((i == 1) ? 3'b000 : 3'b001)) begin
                errors++;
                $display("FAIL cond_eq i%0d got %b want %b", i, shift,
                         (i == 1) ? 3'b000 : 3'b001);
            end
        end
        tick;
        less = 1; eq = 0; #1;
        checks++;
        if ({pc, shift} !== {3'd1, 3'b110}) begin
            errors++;
            $display("FAIL cond_less got pc=%0d s=%b want 1 110", pc, shift);
        end
        less = 0; #1;
        checks++;
        if (shift !== 3'b101) begin
            errors++;
            $display("FAIL cond_gt got %b want 101", shift);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL cond_done got %b want 1", done);
        end
    endtask

    task automatic test_busy_gating;
        do_reset;
        send(2, 0, 0, mk(0, 1, 1, 2, 3, 0, 0, 0, 3'b011, 10));
        pulse_start;
        tick;
        cbus.cmd_valid = 1; cbus.cmd = 2; cbus.cmd_chan = 0;
        cbus.cmd_row_addr = 0; cbus.cmd_data = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        start = 1;
        #1;
        checks++;
        if ({cbus.cmd_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL gate_ready got r=%b b=%b want 0 1", cbus.cmd_ready, busy);
        end
        tick;
        cbus.cmd_valid = 0; start = 0; #1;
        checks++;
        if ({opcode, src1, src2, shift_dir, pc} !== {1'b1, 2'd2, 2'd3, 3'b011, 3'd0}) begin
            errors++;
            $display("FAIL gate_buf got op=%b s1=%0d s2=%0d dir=%b pc=%0d",
                     opcode, src1, src2, shift_dir, pc);
        end
        n = 0;
        for (int i = 4; i <= 11; i++) begin
            tick;
            if (done) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL gate_early_done got %0d pulses want 0", n);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL gate_done got %b want 1", done);
        end
        tick;
        pulse_start;
        n = 1;
        while (!done && n < 30) begin
            tick;
            n++;
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL gate_rerun got done at cycle %0d want 12", n);
        end
    endtask

    task automatic test_reset_abort;
        do_reset;
        send(0, 0, 5, 0);
        send(1, 0, 7, 0);
        send(2, 0, 0, mk(1, 0, 0, 0, 0, 1, 0, 0, 3'b001, 3));
        send(2, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        pulse_start;
        repeat (4) tick;
        checks++;
        if ({row_active, row_addr, pc} !== {3'b001, 10'd6, 3'd1}) begin
            errors++;
            $display("FAIL abort_wait got ra=%b a=%0d pc=%0d want 001 6 1",
                     row_active, row_addr, pc);
        end
        tick;
        reset = 1; #1;
        checks++;
        if ({row_active, busy, done, pc, cbus.cmd_ready}
            !== {3'b000, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_reset got ra=%b b=%b d=%b pc=%0d r=%b",
                     row_active, busy, done, pc, cbus.cmd_ready);
        end
        @(negedge clk); reset = 0;
        n = 0;
        repeat (3) begin
            tick;
            if (done || busy) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles want 0", n);
        end
        pulse_start;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (shift !== 3'b001) begin
                errors++;
                $display("FAIL abort_rerun i%0d got %b want 001", i, shift);
            end
            tick;
        end
        checks++;
        if ({pc, shift, row_active, busy, done} !== {3'd1, 3'b000, 3'b000, 2'b10}) begin
            errors++;
            $display("FAIL abort_fin got pc=%0d s=%b ra=%b b=%b d=%b",
                     pc, shift, row_active, busy, done);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_done got %b want 1", done);
        end
    endtask

    initial begin
        cbus.cmd_valid = 0; cbus.cmd = 0; cbus.cmd_chan = 0;
        cbus.cmd_row_addr = 0; cbus.cmd_data = 0;
        test_reset;
        test_basic;
        test_row_wait;
        test_dual_wrap;
        test_cond;
        test_busy_gating;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
